// File: rtl/collision_arbiter_if.sv
// Hit-request / collision-grant bundle between the playfield hit sources and the arbiter.
interface collision_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic               startOfFrame;
    logic [NUM_REQ-1:0] hitReq;
    logic               grantValid;
    logic [ID_W-1:0]    grantId;
    logic [NUM_REQ-1:0] pendingMask;
    logic [7:0]         dropCount;

    modport master (
        output startOfFrame, hitReq,
        input  grantValid, grantId, pendingMask, dropCount
    );

    modport slave (
        input  startOfFrame, hitReq,
        output grantValid, grantId, pendingMask, dropCount
    );
endinterface

// File: rtl/collision_arbiter.sv
// Per-frame collision hit arbiter with per-requester cooldown lockout.
// Define ROUND_ROBIN_EN for rotating priority; default is lowest-index-wins.
//
// state | meaning
// IDLE  | waiting for startOfFrame
// ARB   | startOfFrame cycle; winner picked from registered pend and registered
// GRANT | grantValid high for one cycle; startOfFrame here re-enters ARB
module collision_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int ID_W            = 2,
    parameter int COOLDOWN_FRAMES = 3
) (
    input  logic                 clk,
    input  logic                 resetN,
    collision_arbiter_if.slave   bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ARB   = 2'd1;
    localparam logic [1:0] GRANT = 2'd2;

    logic [1:0]         state_q, state_d, state_cur;
    logic [NUM_REQ-1:0] hit_prev_q;
    logic [NUM_REQ-1:0] pend_q, pend_d;
    logic [3:0]         cool_q [NUM_REQ];
    logic [3:0]         cool_d [NUM_REQ];
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic [7:0]         drop_cnt_q, drop_cnt_d;

    logic               any_pend;
    logic               grant_fire;
    logic [ID_W-1:0]    win_id;
    logic [NUM_REQ-1:0] win_oh, grant_oh;
    logic [NUM_REQ-1:0] edge_v, busy, accept, drop;

`ifdef ROUND_ROBIN_EN
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic               found;
    int                 idx;

    always_comb begin
        win_id = '0;
        win_oh = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!found && pend_q[idx]) begin
                found       = 1'b1;
                win_id      = ID_W'(idx);
                win_oh[idx] = 1'b1;
            end
        end
    end
`else
    always_comb begin
        win_id = '0;
        win_oh = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                win_id    = ID_W'(i);
                win_oh    = '0;
                win_oh[i] = 1'b1;
            end
        end
    end
`endif

    assign any_pend  = |pend_q;
    assign state_cur = bus.startOfFrame ? ARB : state_q;

    always_comb begin
        state_d    = IDLE;
        grant_fire = 1'b0;
        case (state_cur)
            IDLE:    state_d = IDLE;
            ARB: begin
                grant_fire = any_pend;
                state_d    = any_pend ? GRANT : IDLE;
            end
            GRANT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign grant_oh = grant_fire ? win_oh : '0;

    // A requester is busy while still pending or locked out by its cooldown.
    always_comb begin
        edge_v = bus.hitReq & ~hit_prev_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            busy[i] = pend_q[i] | (cool_q[i] != 4'd0);
        end
        drop   = edge_v & busy;
        accept = edge_v & ~busy & ~grant_oh;
        pend_d = (pend_q & ~grant_oh) | accept;
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            cool_d[i] = cool_q[i];
            if (grant_oh[i]) begin
                cool_d[i] = 4'(COOLDOWN_FRAMES);
            end else if (bus.startOfFrame && cool_q[i] != 4'd0) begin
                cool_d[i] = cool_q[i] - 4'd1;
            end
        end
        drop_cnt_d = drop_cnt_q;
        if (|drop && drop_cnt_q != 8'hFF) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
        grant_id_d = grant_fire ? win_id : grant_id_q;
    end

`ifdef ROUND_ROBIN_EN
    assign ptr_d = grant_fire ? win_id : ptr_q;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            ptr_q <= ID_W'(NUM_REQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= IDLE;
            hit_prev_q <= '0;
            pend_q     <= '0;
            grant_id_q <= '0;
            drop_cnt_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                cool_q[i] <= 4'd0;
            end
        end else begin
            state_q    <= state_d;
            hit_prev_q <= bus.hitReq;
            pend_q     <= pend_d;
            grant_id_q <= grant_id_d;
            drop_cnt_q <= drop_cnt_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                cool_q[i] <= cool_d[i];
            end
        end
    end

    assign bus.grantValid  = (state_q == GRANT);
    assign bus.grantId     = grant_id_q;
    assign bus.pendingMask = pend_q;
    assign bus.dropCount   = drop_cnt_q;
endmodule

// File: tb/tb_collision_arbiter.sv
// Directed bench for collision_arbiter (NUM_REQ=4, COOLDOWN_FRAMES=2).
module tb_collision_arbiter;
    logic clk;
    logic resetN;
    int   n_checks;
    int   n_errors;

    collision_arbiter_if #(.NUM_REQ(4), .ID_W(2)) bus ();

    collision_arbiter #(
        .NUM_REQ        (4),
        .ID_W           (2),
        .COOLDOWN_FRAMES(2)
    ) dut (
        .clk   (clk),
        .resetN(resetN),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_hit(input logic [3:0] mask);
        bus.hitReq = mask;
        tick();
        bus.hitReq = 4'b0000;
    endtask

    // Drives one startOfFrame cycle; returns the outputs seen in the cycle after it.
    task automatic do_frame(output logic gv, output logic [1:0] gid);
        bus.startOfFrame = 1'b1;
        tick();
        bus.startOfFrame = 1'b0;
        gv  = bus.grantValid;
        gid = bus.grantId;
    endtask

    task automatic apply_reset();
        resetN = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetN = 1'b1;
        tick();
    endtask

    logic       gv;
    logic [1:0] gid;
    int         grants;

    initial begin
        n_checks         = 0;
        n_errors         = 0;
        bus.startOfFrame = 1'b0;
        bus.hitReq       = 4'b0000;

        apply_reset();
        chk("rst_grantValid", 32'(bus.grantValid), 32'd0);
        chk("rst_grantId", 32'(bus.grantId), 32'd0);
        chk("rst_pending", 32'(bus.pendingMask), 32'd0);
        chk("rst_drop", 32'(bus.dropCount), 32'd0);

        // Single hit on requester 2
        pulse_hit(4'b0100);
        chk("single_pend", 32'(bus.pendingMask), 32'h4);
        tick();
        do_frame(gv, gid);
        chk("single_gv", 32'(gv), 32'd1);
        chk("single_gid", 32'(gid), 32'd2);
        chk("single_pend_clr", 32'(bus.pendingMask), 32'd0);
        tick();
        chk("single_gv_1cyc", 32'(bus.grantValid), 32'd0);

        // Cooldown: two frames of dropped hits, third frame granted
        for (int f = 0; f < 2; f++) begin
            pulse_hit(4'b0100);
            tick();
            do_frame(gv, gid);
            chk("cool_nogrant", 32'(gv), 32'd0);
            tick();
        end
        chk("cool_drop", 32'(bus.dropCount), 32'd2);
        pulse_hit(4'b0100);
        chk("cool_pend", 32'(bus.pendingMask), 32'h4);
        tick();
        do_frame(gv, gid);
        chk("cool_gv", 32'(gv), 32'd1);
        chk("cool_gid", 32'(gid), 32'd2);
        tick();

        // Simultaneous hits on 1 and 3
        pulse_hit(4'b1010);
        chk("simul_pend", 32'(bus.pendingMask), 32'hA);
        tick();
        do_frame(gv, gid);
        chk("simul_gid_a", 32'(gid), 32'd1);
        chk("simul_pend_a", 32'(bus.pendingMask), 32'h8);
        tick();
        do_frame(gv, gid);
        chk("simul_gv_b", 32'(gv), 32'd1);
        chk("simul_gid_b", 32'(gid), 32'd3);
        chk("simul_pend_b", 32'(bus.pendingMask), 32'd0);
        tick();

        // From reset, all four pending: 0,1,2,3 on successive frames
        apply_reset();
        pulse_hit(4'b1111);
        chk("all_pend", 32'(bus.pendingMask), 32'hF);
        for (int k = 0; k < 4; k++) begin
            tick();
            do_frame(gv, gid);
            chk("all_gv", 32'(gv), 32'd1);
            chk("all_gid", 32'(gid), 32'(k));
        end
        tick();
        chk("all_drop", 32'(bus.dropCount), 32'd0);

        // Edge coincident with startOfFrame is not eligible this frame
        bus.startOfFrame = 1'b1;
        bus.hitReq       = 4'b0001;
        tick();
        bus.startOfFrame = 1'b0;
        bus.hitReq       = 4'b0000;
        chk("same_gv", 32'(bus.grantValid), 32'd0);
        chk("same_pend", 32'(bus.pendingMask), 32'h1);
        tick();
        do_frame(gv, gid);
        chk("same_gv_next", 32'(gv), 32'd1);
        chk("same_gid_next", 32'(gid), 32'd0);
        tick();

        // Requester 1 held high for ten frames
        bus.hitReq = 4'b0010;
        tick();
        chk("stuck_pend", 32'(bus.pendingMask), 32'h2);
        grants = 0;
        for (int f = 0; f < 10; f++) begin
            do_frame(gv, gid);
            if (gv) grants++;
            if (f == 0) chk("stuck_gid", 32'(gid), 32'd1);
            tick();
            tick();
        end
        chk("stuck_grants", 32'(grants), 32'd1);
        chk("stuck_drop", 32'(bus.dropCount), 32'd0);
        bus.hitReq = 4'b0000;
        tick();

        // Reset asserted during the GRANT cycle
        pulse_hit(4'b1100);
        chk("rstg_pend", 32'(bus.pendingMask), 32'hC);
        tick();
        do_frame(gv, gid);
        chk("rstg_gv_pre", 32'(gv), 32'd1);
        chk("rstg_gid_pre", 32'(gid), 32'd2);
        resetN = 1'b0;
        #1;
        chk("rstg_gv", 32'(bus.grantValid), 32'd0);
        chk("rstg_gid", 32'(bus.grantId), 32'd0);
        chk("rstg_pend0", 32'(bus.pendingMask), 32'd0);
        chk("rstg_drop", 32'(bus.dropCount), 32'd0);
        @(posedge clk);
        #1;
        resetN = 1'b1;
        tick();
        grants = 0;
        for (int f = 0; f < 3; f++) begin
            do_frame(gv, gid);
            if (gv) grants++;
            tick();
        end
        chk("rstg_nogrant", 32'(grants), 32'd0);
        chk("rstg_pend_after", 32'(bus.pendingMask), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/collision_arbiter.md
# collision_arbiter

Per-frame arbiter for collision hit requests in the pinball game logic. It captures rising edges on up to NUM_REQ hit lines (walls, flippers, bumpers) and arbitrates once per video frame at startOfFrame. It issues at most one collision grant per frame to the ball-physics block. After a requester is granted, it is locked out for a programmable number of frames so that a ball resting against an object does not re-trigger.

## Interface
- NUM_REQ, 4: number of hit requesters (2..16).
- ID_W, 2: width of grantId; must satisfy 2^ID_W >= NUM_REQ.
- COOLDOWN_FRAMES, 3: frames a granted requester is ignored (1..15).

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous, active-low reset.
- startOfFrame  in  1  one-cycle pulse at the start of each frame.
- hitReq  in  NUM_REQ  level hit signal per requester.
- grantValid  out  1  one-cycle pulse; a grant was issued this frame.
- grantId  out  ID_W  index of the granted requester; held until the next grant.
- pendingMask  out  NUM_REQ  registered pending bits.
- dropCount  out  8  saturating count of edges that were ignored.

## Operation
- Edge capture: hitPrev[i] samples hitReq[i] every cycle. An edge on requester i is hitReq[i]=1 with hitPrev[i]=0.
- An edge on requester i is accepted when all three hold, using registered values:
  - pend[i]=0
  - cooldown[i]=0
  - i is not the requester being granted in this same cycle.
- An accepted edge sets pend[i] on the next clock.
- An edge is dropped when pend[i]=1 or cooldown[i]!=0. Each dropped edge increments dropCount by 1, saturating at 255. If several edges are dropped in one cycle, dropCount still increments by 1.
- Arbitration occurs only on cycles with startOfFrame=1, and only over the registered pend vector. An edge arriving in the same cycle is captured but is not eligible until the next frame.
  - If pend is all zero: no grant; grantValid stays 0.
  - Otherwise select winner w. Next cycle:
    - grantValid=1 and grantId=w
    - pend[w] is cleared
    - cooldown[w] is loaded with COOLDOWN_FRAMES.
- Cooldown: on every startOfFrame, each nonzero cooldown[i] decrements by 1. Exception: the winner is loaded in that frame rather than decremented. Each cooldown counter is 4 bits wide and never wraps below 0.
- Requests that lose arbitration stay pending with no aging, and compete again in later frames.
- Selection policy: fixed priority (lowest index wins), unless ROUND_ROBIN_EN is defined.
- Internal state machine, one cycle per state:
  - IDLE → ARB on startOfFrame.
  - ARB → GRANT if any pend bit is set, otherwise ARB → IDLE.
  - GRANT → IDLE.
  - ARB occupies the startOfFrame cycle itself; the winner is registered at that clock edge.
- Reset mid-operation clears all state immediately: pend, hitPrev, cooldowns, state, pointer and outputs. A grant in flight is lost.

## Timing
- Reset values:
  - grantValid=0, grantId=0, pendingMask=0, dropCount=0
  - all cooldowns=0, hitPrev=0, state=IDLE
  - round-robin pointer=NUM_REQ-1, so requester 0 is first after reset.
- Edge → pendingMask bit set: 1 cycle.
- startOfFrame → grantValid: exactly 1 cycle later. grantValid is high for exactly 1 cycle.
- pendingMask reflects the cleared winner bit in the same cycle that grantValid=1.
- At most one grant between consecutive startOfFrame pulses. If startOfFrame pulses on back-to-back cycles, each pulse arbitrates: GRANT → ARB directly.
- hitReq is assumed already synchronous to clk; no synchronizers are included.

## Configuration
- ROUND_ROBIN_EN defined:
  - A registered pointer holds the last winner.
  - The search for a winner starts at pointer+1, modulo NUM_REQ.
  - The pointer is updated to w on each grant.
- ROUND_ROBIN_EN not defined:
  - Fixed priority: lowest pending index wins.
  - The pointer register is not built.

## Test plan
Settings: NUM_REQ=4, COOLDOWN_FRAMES=2.
- Single hit: pulse hitReq[2] mid-frame → pendingMask=4'b0100 next cycle; at next startOfFrame+1, grantValid=1, grantId=2, pendingMask=0.
- Cooldown: after grant of requester 2, hit on requester 2 in each of the next two frames → dropped, dropCount=2, no grant. A hit in the third frame → granted.
- Simultaneous hits: hitReq=4'b1010 in one cycle.
  - Fixed priority: grants id 1, then id 3 on the next frame.
  - Round-robin from reset with 4'b1111 held pending: grants 0,1,2,3 on successive frames.
- Same-cycle edge: hitReq[0] rises on the startOfFrame cycle with pend empty → no grant this frame; grantId=0 on the following frame.
- Stuck high: hitReq[1] held at 1 for 10 frames → exactly one grant; dropCount unchanged, since no new edges occur.
- Reset mid-grant: assert resetN=0 on the GRANT cycle → all outputs are 0 immediately; pending requests from before reset are not granted after release.
